// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - Z80 bus slave: byte memory with wait-state insertion and optional I/O latch
//
// Responds to Z80 memory, I/O and interrupt-acknowledge bus cycles.
// Optional feature macro: Z80_RESP_IOREG_EN (8-bit I/O latch answering every port).
//
// Parameters:
//   AW      memory address width (2^AW bytes, addr[AW-1:0] decoded)
//   WS_MEM  wait states for non-M1 memory and I/O cycles
//   WS_M1   wait states for opcode fetch (M1) cycles
// Ports:
//   clk                      system clock, rising edge
//   i_reset_btn              asynchronous active-high reset
//   mreq_n iorq_n rd_n wr_n  CPU bus strobes
//   m1_n rfsh_n              CPU cycle-type strobes
//   addr[15:0]               CPU address
//   cpu_dout[7:0]            CPU write data
//   cpu_din[7:0]             registered read data to CPU
//   wait_n                   registered wait request (low = stretch)
//   ld_we ld_addr ld_data    host preload write port
//   busy                     high while the FSM is not idle

module z80_bus_responder #(
    parameter int AW     = 12,
    parameter int WS_MEM = 0,
    parameter int WS_M1  = 1
) (
    input  logic          clk,
    input  logic          i_reset_btn,
    input  logic          mreq_n,
    input  logic          iorq_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          m1_n,
    input  logic          rfsh_n,
    input  logic [15:0]   addr,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          wait_n,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          busy
);

    localparam int WS_MAX = (WS_M1 > WS_MEM) ? WS_M1 : WS_MEM;
    localparam int CW     = (WS_MAX < 1) ? 1 : $clog2(WS_MAX + 1);
    localparam logic [CW-1:0] C_WS_M1  = CW'(WS_M1);
    localparam logic [CW-1:0] C_WS_MEM = CW'(WS_MEM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_wr, w_wr_nx;
    logic          r_io, w_io_nx;
    logic          r_inta, w_inta_nx;
    logic          r_wait_n, w_wait_n_nx;
    logic [7:0]    r_cpu_din;
    logic [7:0]    r_mem [2**AW];

    logic [AW-1:0] w_a;
    logic          w_mem_cyc;
    logic          w_io_cyc;
    logic          w_inta_cyc;
    logic          w_bus_idle;
    logic          w_abort;
    logic          w_mem_we;

    assign w_a        = addr[AW-1:0];
    // Refresh cycles also pull mreq_n low; rfsh_n keeps them from being decoded.
    assign w_mem_cyc  = !mreq_n && rfsh_n && (!rd_n || !wr_n);
    assign w_io_cyc   = !iorq_n && m1_n && (!rd_n || !wr_n);
    assign w_inta_cyc = !iorq_n && !m1_n;
    assign w_bus_idle = mreq_n && iorq_n && rd_n && wr_n;
    // Cycle vanished before the access happened: either request or direction strobe dropped.
    assign w_abort    = (mreq_n && iorq_n) || (rd_n && wr_n);
    assign w_mem_we   = (r_state == ACCESS) && r_wr && !r_io && !r_inta;

    generate
        if (AW < 16) begin : g_addr_hi
            logic w_unused_addr;
            assign w_unused_addr = &{1'b0, addr[15:AW]};
        end
    endgenerate

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_wr_nx    = r_wr;
        w_io_nx    = r_io;
        w_inta_nx  = r_inta;
        case (r_state)
            IDLE: begin
                if (w_inta_cyc) begin
                    w_state_nx = ACCESS;
                    w_cnt_nx   = '0;
                    w_wr_nx    = 1'b0;
                    w_io_nx    = 1'b0;
                    w_inta_nx  = 1'b1;
                end else if (w_mem_cyc) begin
                    w_state_nx = WAIT;
                    w_cnt_nx   = m1_n ? C_WS_MEM : C_WS_M1;
                    w_wr_nx    = !wr_n;
                    w_io_nx    = 1'b0;
                    w_inta_nx  = 1'b0;
                end else if (w_io_cyc) begin
                    w_state_nx = WAIT;
                    w_cnt_nx   = C_WS_MEM;
                    w_wr_nx    = !wr_n;
                    w_io_nx    = 1'b1;
                    w_inta_nx  = 1'b0;
                end
            end
            WAIT: begin
                if (w_abort) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_state_nx = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nx = HOLD;
            end
            HOLD: begin
                if (w_bus_idle) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        // wait_n is registered, so it is derived from where the FSM will be next cycle.
        w_wait_n_nx = !((w_state_nx == WAIT) && (w_cnt_nx != '0));
    end

    always_ff @(posedge clk or posedge i_reset_btn) begin
        if (i_reset_btn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_io     <= 1'b0;
            r_inta   <= 1'b0;
            r_wait_n <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_wr     <= w_wr_nx;
            r_io     <= w_io_nx;
            r_inta   <= w_inta_nx;
            r_wait_n <= w_wait_n_nx;
        end
    end

`ifdef Z80_RESP_IOREG_EN
    logic [7:0] r_io_latch;

    always_ff @(posedge clk or posedge i_reset_btn) begin
        if (i_reset_btn) begin
            r_io_latch <= 8'h00;
        end else if ((r_state == ACCESS) && r_io && r_wr && !r_inta) begin
            r_io_latch <= cpu_dout;
        end
    end
`endif

    always_ff @(posedge clk or posedge i_reset_btn) begin
        if (i_reset_btn) begin
            r_cpu_din <= 8'h00;
        end else if (r_state == ACCESS) begin
            if (r_inta) begin
                // RST 38h opcode for interrupt mode 0
                r_cpu_din <= 8'hFF;
            end else if (r_io) begin
                if (!r_wr) begin
`ifdef Z80_RESP_IOREG_EN
                    r_cpu_din <= r_io_latch;
`else
                    r_cpu_din <= 8'hFF;
`endif
                end
            end else if (!r_wr) begin
                r_cpu_din <= r_mem[w_a];
            end
        end
    end

    // Memory is never cleared by reset; the CPU write is issued last so it wins a collision.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
        if (w_mem_we) begin
            r_mem[w_a] <= cpu_dout;
        end
    end

    assign cpu_din = r_cpu_din;
    assign wait_n  = r_wait_n;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb/tb_z80_bus_responder.sv - directed self-checking bench for z80_bus_responder
module tb_z80_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [15:0] addr;
    logic [7:0]  cpu_dout;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  din0, din3;
    logic        wn0, wn3, busy0, busy3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    z80_bus_responder u0 (
        .clk(clk), .i_reset_btn(rst), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .addr(addr), .cpu_dout(cpu_dout), .cpu_din(din0),
        .wait_n(wn0), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy0)
    );

    z80_bus_responder #(.WS_MEM(3)) u3 (
        .clk(clk), .i_reset_btn(rst), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .addr(addr), .cpu_dout(cpu_dout), .cpu_din(din3),
        .wait_n(wn3), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // One complete bus cycle paced by the selected instance's wait_n.
    // io && m1 gives an interrupt acknowledge.
    task automatic bus(input bit sel3, input bit m1, input bit io, input bit wr,
                       input logic [15:0] a, input logic [7:0] d,
                       output int lows, output logic [7:0] rdata);
        int n;
        @(negedge clk);
        addr = a; cpu_dout = d; m1_n = !m1;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        if (wr) wr_n = 1'b0; else if (!(io && m1)) rd_n = 1'b0;
        lows = 0; n = 0;
        @(negedge clk);
        while (((sel3 ? wn3 : wn0) === 1'b0) && n < 20) begin
            lows++; n++;
            @(negedge clk);
        end
        chk("wait_bound", 16'(n < 20), 16'd1);
        repeat (2) @(negedge clk);
        rdata = sel3 ? din3 : din0;
        bus_idle();
        @(negedge clk);
    endtask

    initial begin
        int         lows;
        logic [7:0] rd;
        logic [7:0] io_exp;
`ifdef Z80_RESP_IOREG_EN
        io_exp = 8'h3C;
`else
        io_exp = 8'hFF;
`endif
        rst = 1'b1; bus_idle(); addr = 16'h0; cpu_dout = 8'h0;
        ld_we = 1'b0; ld_addr = 12'h0; ld_data = 8'h0;
        repeat (2) @(negedge clk);
        chk("rst_wait_n", 16'(wn0), 16'd1);
        chk("rst_busy", 16'(busy0), 16'd0);
        chk("rst_din", 16'(din0), 16'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy_u3", 16'(busy3), 16'd0);

        preload(12'h000, 8'hFD);
        preload(12'h001, 8'h07);
        preload(12'h002, 8'hFF);
        preload(12'h123, 8'h11);

        bus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, lows, rd);
        chk("m1_0000_lows", 16'(lows), 16'd1);
        chk("m1_0000_din", 16'(rd), 16'h00FD);
        bus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 8'h00, lows, rd);
        chk("m1_0001_lows", 16'(lows), 16'd1);
        chk("m1_0001_din", 16'(rd), 16'h0007);

        // u3 is still waiting when the strobes drop: its cycle aborts without writing
        bus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0123, 8'h5A, lows, rd);
        chk("wr_0123_lows", 16'(lows), 16'd0);
        chk("wr_busy_after", 16'(busy0), 16'd0);
        chk("abort_busy_u3", 16'(busy3), 16'd0);
        chk("abort_wait_n_u3", 16'(wn3), 16'd1);

        bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, lows, rd);
        chk("rd_0123_lows", 16'(lows), 16'd0);
        chk("rd_0123_din", 16'(rd), 16'h005A);

        bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, lows, rd);
        chk("ws3_lows", 16'(lows), 16'd3);
        chk("ws3_abort_nowrite", 16'(rd), 16'h0011);

        // Refresh with a write strobe present must still be ignored
        @(negedge clk);
        addr = 16'h0123; cpu_dout = 8'hEE; mreq_n = 1'b0; rfsh_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rfsh_busy", 16'(busy0), 16'd0);
        chk("rfsh_wait_n", 16'(wn0), 16'd1);
        chk("rfsh_busy_u3", 16'(busy3), 16'd0);
        bus_idle();
        bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, lows, rd);
        chk("rfsh_mem_kept", 16'(rd), 16'h005A);

        bus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 8'h3C, lows, rd);
        chk("io_wr_lows", 16'(lows), 16'd0);
        bus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, lows, rd);
        chk("io_rd_din", 16'(rd), 16'(io_exp));

        bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, lows, rd);
        chk("rd_0000_din", 16'(rd), 16'h00FD);
        bus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, lows, rd);
        chk("inta_lows", 16'(lows), 16'd0);
        chk("inta_din", 16'(rd), 16'h00FF);

        // Host preload and CPU write to the same byte on the ACCESS edge
        @(negedge clk);
        addr = 16'h0200; cpu_dout = 8'h77; mreq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        ld_we = 1'b1; ld_addr = 12'h200; ld_data = 8'h99;
        @(negedge clk);
        ld_we = 1'b0; bus_idle();
        @(negedge clk);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0200, 8'h00, lows, rd);
        chk("collide_cpu_wins", 16'(rd), 16'h0077);
        bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 8'h00, lows, rd);
        chk("preload_only_u3", 16'(rd), 16'h0099);

        // Reset during the wait phase of a write
        preload(12'h300, 8'hAB);
        @(negedge clk);
        addr = 16'h0300; cpu_dout = 8'h55; mreq_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        chk("wait_phase_wn_u3", 16'(wn3), 16'd0);
        chk("wait_phase_busy_u3", 16'(busy3), 16'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_wait_n_u3", 16'(wn3), 16'd1);
        chk("midrst_busy_u3", 16'(busy3), 16'd0);
        chk("midrst_busy_u0", 16'(busy0), 16'd0);
        chk("midrst_din_u3", 16'(din3), 16'h0000);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 8'h00, lows, rd);
        chk("midrst_lows_u3", 16'(lows), 16'd3);
        chk("midrst_kept_u3", 16'(rd), 16'h00AB);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0300, 8'h00, lows, rd);
        chk("midrst_kept_u0", 16'(rd), 16'h00AB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 SHALL have parameter AW, default 12, giving the memory address width (2^AW bytes, addr[AW-1:0] used, upper bits ignored).
REQ-002 SHALL have parameter WS_MEM, default 0, setting wait states for non-M1 memory read/write.
REQ-003 SHALL have parameter WS_M1, default 1, setting wait states for opcode fetch (M1).
REQ-004 SHALL have port clk  in  1  single system clock, all state on rising edge.
REQ-005 SHALL have port i_reset_btn  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  Z80 bus strobes from the CPU.
REQ-007 SHALL have port addr  in  16  CPU address bus.
REQ-008 SHALL have port cpu_dout  in  8  CPU write data.
REQ-009 SHALL have port cpu_din  out  8  read data to CPU, registered.
REQ-010 SHALL have port wait_n  out  1  wait request to CPU, registered, low = stretch.
REQ-011 SHALL have ports ld_we  in  1, ld_addr  in  AW, ld_data  in  8  host preload port for memory.
REQ-012 SHALL have port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS, HOLD.
REQ-014 IDLE->WAIT SHALL occur when mreq_n=0, rfsh_n=1 and (rd_n=0 or wr_n=0) are sampled; the wait counter SHALL load WS_M1 if m1_n=0, else WS_MEM.
REQ-015 IDLE->WAIT SHALL also occur for I/O cycles: iorq_n=0, m1_n=1, (rd_n=0 or wr_n=0); the counter SHALL load WS_MEM.
REQ-016 Interrupt acknowledge (iorq_n=0 and m1_n=0) SHALL enter ACCESS directly and drive cpu_din=8'hFF (RST 38h).
REQ-017 In WAIT, wait_n SHALL be 0 while counter>0 and SHALL decrement once per clk; at counter=0 FSM SHALL go to ACCESS with wait_n=1 (zero wait states pass through WAIT in one cycle with wait_n=1).
REQ-018 In ACCESS a memory read SHALL register mem[addr] into cpu_din; a memory write SHALL store cpu_dout to mem[addr]; exactly one access per bus cycle.
REQ-019 ACCESS->HOLD SHALL be unconditional; HOLD->IDLE SHALL occur when all of mreq_n, iorq_n, rd_n, wr_n are sampled 1.
REQ-020 Refresh cycles (rfsh_n=0) SHALL be ignored: no access, wait_n stays 1.
REQ-021 cpu_din SHALL hold its last value outside ACCESS.
REQ-022 Strobes deasserted before ACCESS (aborted cycle) SHALL return FSM to IDLE with no memory write and wait_n=1 next cycle.
REQ-023 ld_we=1 SHALL write ld_data to mem[ld_addr] in the same cycle; on collision with an ACCESS write to the same address, the CPU write SHALL win.
REQ-024 Wait counter width SHALL be wide enough for max(WS_M1, WS_MEM) without wrap.

Reset
REQ-025 i_reset_btn=1 SHALL asynchronously force FSM=IDLE, counter=0, wait_n=1, cpu_din=8'h00, busy=0, I/O latch=8'h00 (when present).
REQ-026 Reset mid-cycle SHALL abort the access; memory contents SHALL NOT be cleared by reset.
REQ-027 After reset release, the first bus cycle SHALL be recognised no earlier than the next rising clk.

Configuration
REQ-028 Macro Z80_RESP_IOREG_EN defined: an 8-bit I/O latch SHALL respond to any I/O port; I/O write stores cpu_dout, I/O read returns the latch.
REQ-029 Macro Z80_RESP_IOREG_EN undefined: I/O writes SHALL be ignored and I/O reads SHALL return 8'hFF; wait timing is unchanged.

Verification
REQ-030 Preload mem[0..2]=FD,07,FF, run CPU from reset with AF=8800 -> two M1 fetches at 0000/0001 each with exactly 1 wait_n-low cycle, cpu_din=FD then 07, CPU ends AF=1101, PC=0002.
REQ-031 Memory write 0x5A to 0x0123 with WS_MEM=0 then read back -> wait_n never low, cpu_din=8'h5A.
REQ-032 WS_MEM=3, memory read -> wait_n low for exactly 3 consecutive clocks, then ACCESS.
REQ-033 Refresh cycle (mreq_n=0, rfsh_n=0) -> no state change, busy=0, memory unchanged.
REQ-034 With Z80_RESP_IOREG_EN: OUT (n),0x3C then IN -> 8'h3C; without it: IN -> 8'hFF.
REQ-035 Assert i_reset_btn during WAIT of a write -> wait_n=1 and busy=0 immediately, target byte unchanged.
